// File: rtl/instruction_memory_pkg.sv
// Shared types and constants for the pipelined instruction memory:
// load/run state encoding, the NOP returned on errors, and response error codes.
package instruction_memory_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_MISALIGNED = 2'b01;
    localparam logic [1:0] ERR_RANGE      = 2'b10;

endpackage

// File: rtl/instruction_memory_array.sv
// Single-port-style instruction store: one synchronous write port, one synchronous
// read port, no reset so that it maps onto block RAM.
module instruction_memory_array
    import instruction_memory_pkg::*;
#(
    parameter int MEMORY_SIZE      = 1024,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int ADDR_W           = $clog2(MEMORY_SIZE)
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [INSTRUCTION_SIZE-1:0] wr_data,
    input  logic                        rd_en,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic [INSTRUCTION_SIZE-1:0] rd_data
);

    logic [INSTRUCTION_SIZE-1:0] mem [MEMORY_SIZE];

    // The read register only updates on rd_en, so it doubles as the held response data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instruction_memory_pipelined.sv
// Clocked instruction memory between fetch and decode: valid/ready fetch requests,
// a registered response with backpressure, and a program-load port gated by a load/run FSM.
module instruction_memory_pipelined
    import instruction_memory_pkg::*;
#(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int MEMORY_SIZE      = 1024,
    parameter int IDX_W            = $clog2(MEMORY_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [WORDSIZE-1:0]         req_pc,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [INSTRUCTION_SIZE-1:0] resp_instruction,
    output logic [WORDSIZE-1:0]         resp_pc,
    output logic [1:0]                  resp_error,
    input  logic                        flush,
    input  logic                        load_start,
    input  logic                        load_valid,
    input  logic [IDX_W-1:0]            load_index,
    input  logic [INSTRUCTION_SIZE-1:0] load_data,
    input  logic                        load_done,
    output logic                        loading
);

    state_t                      state;
    state_t                      state_next;
    logic                        accept;
    logic                        misaligned;
    logic                        out_of_range;
    logic [1:0]                  fetch_error;
    logic [IDX_W-1:0]            fetch_index;
    logic                        rd_en;
    logic                        wr_en;
    logic [INSTRUCTION_SIZE-1:0] rd_data;
    logic                        resp_nop;

    assign req_ready = (state == RUN) && !flush && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;
    assign loading   = (state != RUN);

    // Range check uses the whole word index so high PCs never alias into the array.
    assign misaligned   = (req_pc[1:0] != 2'b00);
    assign out_of_range = ({2'b00, req_pc[WORDSIZE-1:2]} >= WORDSIZE'(MEMORY_SIZE));
    assign fetch_index  = req_pc[IDX_W+1:2];

    always_comb begin
        fetch_error = ERR_NONE;
        if (misaligned) begin
            fetch_error = ERR_MISALIGNED;
        end else if (out_of_range) begin
            fetch_error = ERR_RANGE;
        end
    end

    assign rd_en = accept && (fetch_error == ERR_NONE);
    assign wr_en = (state == LOAD) && load_valid;

    instruction_memory_array #(
        .MEMORY_SIZE      (MEMORY_SIZE),
        .INSTRUCTION_SIZE (INSTRUCTION_SIZE),
        .ADDR_W           (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (load_index),
        .wr_data (load_data),
        .rd_en   (rd_en),
        .rd_addr (fetch_index),
        .rd_data (rd_data)
    );

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (load_done) state_next = RUN;
            RUN:     if (load_start) state_next = DRAIN;
            DRAIN:   if (!resp_valid || resp_ready || flush) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Response register; resp_nop selects the NOP instead of the RAM read register
    // for errored fetches and after reset, when the RAM output is meaningless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_pc    <= '0;
            resp_error <= ERR_NONE;
            resp_nop   <= 1'b1;
        end else if (flush) begin
            resp_valid <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_pc    <= req_pc;
            resp_error <= fetch_error;
            resp_nop   <= (fetch_error != ERR_NONE);
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    assign resp_instruction = resp_nop ? INSTRUCTION_SIZE'(NOP) : rd_data;

endmodule

// File: tb/tb_instruction_memory_pipelined.sv
// Self-checking bench: directed test-plan sequence with literal expectations, then
// randomized traffic compared every cycle against a behavioural model of the memory.
module tb_instruction_memory_pipelined;

    localparam int WS = 64;
    localparam int IS = 32;
    localparam int MS = 1024;
    localparam int IW = 10;
    localparam logic [31:0] NOP_W = 32'h0000_0013;
    localparam int S_LOAD  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [WS-1:0] req_pc;
    logic          resp_valid;
    logic          resp_ready;
    logic [IS-1:0] resp_instruction;
    logic [WS-1:0] resp_pc;
    logic [1:0]    resp_error;
    logic          flush;
    logic          load_start;
    logic          load_valid;
    logic [IW-1:0] load_index;
    logic [IS-1:0] load_data;
    logic          load_done;
    logic          loading;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [4] = '{32'h06B3_8183, 32'hB673_81A3, 32'h0079_81B3, 32'h41FC_8333};

    instruction_memory_pipelined #(
        .WORDSIZE         (WS),
        .INSTRUCTION_SIZE (IS),
        .MEMORY_SIZE      (MS)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_pc           (req_pc),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_instruction (resp_instruction),
        .resp_pc          (resp_pc),
        .resp_error       (resp_error),
        .flush            (flush),
        .load_start       (load_start),
        .load_valid       (load_valid),
        .load_index       (load_index),
        .load_data        (load_data),
        .load_done        (load_done),
        .loading          (loading)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int          m_state;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [63:0] m_pc;
    logic [1:0]  m_err;
    logic        m_dc;
    logic [31:0] mem_m [MS];
    bit          wr_m  [MS];

    function automatic logic model_ready();
        return (m_state == S_RUN) && !flush && (!m_valid || resp_ready);
    endfunction

    function automatic logic [1:0] pc_error(input logic [63:0] pc);
        if (pc % 64'd4 != 64'd0) return 2'd1;
        if (pc / 64'd4 >= 64'(MS)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic int pc_index(input logic [63:0] pc);
        return int'(pc / 64'd4);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= S_LOAD;
            m_valid <= 1'b0;
            m_instr <= NOP_W;
            m_pc    <= 64'd0;
            m_err   <= 2'd0;
            m_dc    <= 1'b0;
        end else begin
            if (m_state == S_LOAD && load_valid) begin
                mem_m[load_index] <= load_data;
                wr_m[load_index]  <= 1'b1;
            end
            if (req_valid && model_ready()) begin
                m_valid <= 1'b1;
                m_pc    <= req_pc;
                m_err   <= pc_error(req_pc);
                if (pc_error(req_pc) != 2'd0) begin
                    m_instr <= NOP_W;
                    m_dc    <= 1'b0;
                end else begin
                    m_instr <= mem_m[pc_index(req_pc)];
                    m_dc    <= !wr_m[pc_index(req_pc)];
                end
            end else if (flush || resp_ready) begin
                m_valid <= 1'b0;
            end
            case (m_state)
                S_LOAD:  if (load_done) m_state <= S_RUN;
                S_RUN:   if (load_start) m_state <= S_DRAIN;
                S_DRAIN: if (!m_valid || resp_ready || flush) m_state <= S_LOAD;
                default: m_state <= S_LOAD;
            endcase
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_output("model_req_ready", 64'(req_ready), 64'(model_ready()));
            check_output("model_loading", 64'(loading), 64'(m_state != S_RUN));
            check_output("model_resp_valid", 64'(resp_valid), 64'(m_valid));
            if (m_valid) begin
                check_output("model_resp_pc", resp_pc, m_pc);
                check_output("model_resp_error", 64'(resp_error), 64'(m_err));
                if (!m_dc) begin
                    check_output("model_resp_instruction", 64'(resp_instruction), 64'(m_instr));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_loading"}, 64'(loading), 64'd1);
        check_output({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check_output({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check_output({tag, "_resp_instruction"}, 64'(resp_instruction), 64'(NOP_W));
        check_output({tag, "_resp_pc"}, resp_pc, 64'd0);
        check_output({tag, "_resp_error"}, 64'(resp_error), 64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_pc     = '0;
        resp_ready = 1'b0;
        flush      = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_index = '0;
        load_data  = '0;
        load_done  = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");

        // Program load of four instructions
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_index = IW'(i);
            load_data  = prog[i];
            tick();
        end
        load_valid = 1'b0;
        load_done  = 1'b1;
        tick();
        load_done = 1'b0;
        check_output("loaded_loading", 64'(loading), 64'd0);

        // Back-to-back fetches
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_pc = 64'(i) * 64'd4;
            tick();
            check_output("fetch_instruction", 64'(resp_instruction), 64'(prog[i]));
            check_output("fetch_error", 64'(resp_error), 64'd0);
            check_output("fetch_valid", 64'(resp_valid), 64'd1);
        end

        // Error fetches
        req_pc = 64'd6;
        tick();
        check_output("misaligned_error", 64'(resp_error), 64'd1);
        check_output("misaligned_instruction", 64'(resp_instruction), 64'(NOP_W));
        check_output("misaligned_pc", resp_pc, 64'd6);
        req_pc = 64'd4096;
        tick();
        check_output("range_error", 64'(resp_error), 64'd2);
        req_pc = 64'h1_0000_0000;
        tick();
        check_output("alias_error", 64'(resp_error), 64'd2);
        check_output("alias_instruction", 64'(resp_instruction), 64'(NOP_W));

        // Backpressure hold
        req_pc = 64'd0;
        tick();
        resp_ready = 1'b0;
        req_pc     = 64'd8;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("hold_pc", resp_pc, 64'd0);
            check_output("hold_instruction", 64'(resp_instruction), 64'(prog[0]));
            check_output("hold_req_ready", 64'(req_ready), 64'd0);
            check_output("hold_valid", 64'(resp_valid), 64'd1);
        end
        resp_ready = 1'b1;
        #1;
        check_output("release_req_ready", 64'(req_ready), 64'd1);
        tick();
        check_output("release_pc", resp_pc, 64'd8);
        check_output("release_instruction", 64'(resp_instruction), 64'(prog[2]));

        // Flush with a held response
        resp_ready = 1'b0;
        req_pc     = 64'd4;
        tick();
        flush = 1'b1;
        #1;
        check_output("flush_req_ready", 64'(req_ready), 64'd0);
        tick();
        flush = 1'b0;
        check_output("flush_valid", 64'(resp_valid), 64'd0);
        req_valid = 1'b0;
        tick();
        check_output("flush_no_accept", 64'(resp_valid), 64'd0);

        // Drain back to load with a held response
        req_valid = 1'b1;
        req_pc    = 64'd12;
        tick();
        check_output("drain_accept_valid", 64'(resp_valid), 64'd1);
        req_valid  = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check_output("drain_loading", 64'(loading), 64'd1);
        load_valid = 1'b1;
        load_index = IW'(2);
        load_data  = 32'hDEAD_BEEF;
        tick();
        load_valid = 1'b0;
        tick();
        check_output("drain_hold_valid", 64'(resp_valid), 64'd1);
        check_output("drain_hold_pc", resp_pc, 64'd12);
        resp_ready = 1'b1;
        tick();
        check_output("drain_done_valid", 64'(resp_valid), 64'd0);
        load_valid = 1'b1;
        load_index = IW'(0);
        load_data  = NOP_W;
        load_done  = 1'b1;
        tick();
        load_valid = 1'b0;
        load_done  = 1'b0;
        check_output("reload_loading", 64'(loading), 64'd0);
        req_valid = 1'b1;
        req_pc    = 64'd0;
        tick();
        check_output("reload_instruction", 64'(resp_instruction), 64'(NOP_W));
        check_output("reload_error", 64'(resp_error), 64'd0);
        req_pc = 64'd8;
        tick();
        check_output("drain_write_ignored", 64'(resp_instruction), 64'(prog[2]));

        // Asynchronous reset mid-stream
        resp_ready = 1'b0;
        req_pc     = 64'd4;
        tick();
        check_output("pre_reset_valid", 64'(resp_valid), 64'd1);
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        tick();
        rst_n     = 1'b1;
        load_done = 1'b1;
        tick();
        load_done  = 1'b0;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_pc     = 64'd4;
        tick();
        check_output("post_reset_contents", 64'(resp_instruction), 64'(prog[1]));
        req_valid = 1'b0;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            req_valid  = ($urandom_range(3) != 0);
            resp_ready = ($urandom_range(3) != 0);
            flush      = ($urandom_range(15) == 0);
            load_start = ($urandom_range(99) == 0);
            load_done  = ($urandom_range(7) == 0);
            load_valid = ($urandom_range(1) == 0);
            load_index = IW'($urandom_range(47));
            load_data  = $urandom;
            case ($urandom_range(9))
                0, 1, 2, 3, 4, 5: req_pc = 64'($urandom_range(47)) * 64'd4;
                6: req_pc = 64'($urandom_range(47)) * 64'd4 + 64'($urandom_range(3, 1));
                7: req_pc = {$urandom, $urandom};
                8: begin
                    case ($urandom_range(4))
                        0: req_pc = 64'd4092;
                        1: req_pc = 64'd4096;
                        2: req_pc = 64'h1_0000_0000;
                        3: req_pc = 64'hFFFF_FFFF_FFFF_FFFC;
                        default: req_pc = 64'd4095;
                    endcase
                end
                default: req_pc = 64'($urandom_range(MS - 1)) * 64'd4;
            endcase
            tick();
        end
        req_valid  = 1'b0;
        flush      = 1'b0;
        load_start = 1'b0;
        load_done  = 1'b0;
        load_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
